// File: rtl/sif_xa_arbiter_if.sv
// rtl/sif_xa_arbiter_if.sv - requester channels and xa bus bundle for sif_xa_arbiter
interface sif_xa_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    busy;
    logic [ADDR_W-1:0]       xa_addr;
    logic [DATA_W-1:0]       xa_data_wr;
    logic                    xa_wr_s;
    logic                    xa_rd_s;
    logic [DATA_W-1:0]       xa_data_rd;

    // arbiter side: takes requests and read data, drives grants, responses and the xa bus
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, xa_data_rd,
        output req_ready, rsp_valid, rsp_rdata, busy,
        output xa_addr, xa_data_wr, xa_wr_s, xa_rd_s
    );

    // requesters plus SIF side
    modport master (
        output req_valid, req_we, req_addr, req_wdata, xa_data_rd,
        input  req_ready, rsp_valid, rsp_rdata, busy,
        input  xa_addr, xa_data_wr, xa_wr_s, xa_rd_s
    );
endinterface

// File: rtl/sif_xa_arbiter.sv
// rtl/sif_xa_arbiter.sv - round-robin arbiter and access sequencer for the SIF xa port
module sif_xa_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    sif_xa_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   id;
    logic               we;
    logic [CNT_W-1:0]   cnt;
    logic               win_found;
    logic [PTR_W-1:0]   win_id;
    logic [PTR_W:0]     cand;
    logic               accept;
    logic [N_REQ-1:0]   ready;
    logic [N_REQ-1:0]   rsp_hot;
    logic [PTR_W-1:0]   ptr_after_win;

    // round-robin search: first valid requester at or after ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(N_REQ)) begin
                cand = cand - (PTR_W+1)'(N_REQ);
            end
            if (!win_found && bus.req_valid[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[PTR_W-1:0];
            end
        end
    end

    // grant is combinational and only offered while idle and out of reset
    always_comb begin
        accept        = (state == IDLE) && win_found && !rst;
        ready         = '0;
        rsp_hot       = '0;
        ptr_after_win = (win_id == PTR_W'(N_REQ-1)) ? '0 : win_id + 1'b1;
        if (accept) begin
            ready[win_id] = 1'b1;
        end
        rsp_hot[id] = 1'b1;
    end

    assign bus.req_ready = ready;

    // next-state logic for the access sequence
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = we ? RESP : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // datapath: latch the winner, drive the strobe cycle, count read latency, respond
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr            <= '0;
            id             <= '0;
            we             <= 1'b0;
            cnt            <= '0;
            bus.xa_addr    <= '0;
            bus.xa_data_wr <= '0;
            bus.xa_wr_s    <= 1'b0;
            bus.xa_rd_s    <= 1'b0;
            bus.rsp_valid  <= '0;
            bus.rsp_rdata  <= '0;
            bus.busy       <= 1'b0;
        end else begin
            bus.busy      <= (state_next != IDLE);
            bus.rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        id             <= win_id;
                        we             <= bus.req_we[win_id];
                        ptr            <= ptr_after_win;
                        bus.xa_addr    <= bus.req_addr[win_id*ADDR_W +: ADDR_W];
                        bus.xa_data_wr <= bus.req_wdata[win_id*DATA_W +: DATA_W];
                        bus.xa_wr_s    <= bus.req_we[win_id];
                        bus.xa_rd_s    <= ~bus.req_we[win_id];
                    end
                end
                ISSUE: begin
                    bus.xa_wr_s <= 1'b0;
                    bus.xa_rd_s <= 1'b0;
                    if (!we) begin
                        cnt <= CNT_W'(RD_LAT);
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        bus.rsp_rdata <= bus.xa_data_rd;
                    end
                end
                default: ;
            endcase
            if (state_next == RESP) begin
                bus.rsp_valid <= rsp_hot;
            end
        end
    end
endmodule

// File: tb/tb_sif_xa_arbiter.sv
// tb/tb_sif_xa_arbiter.sv - directed and randomized checks of sif_xa_arbiter against a transaction model
module tb_sif_xa_arbiter;
    localparam int N_REQ  = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sif_xa_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sif_xa_arbiter #(
        .N_REQ (N_REQ),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // requester stimulus
    logic              drv_valid [N_REQ];
    logic              drv_we    [N_REQ];
    logic [ADDR_W-1:0] drv_addr  [N_REQ];
    logic [DATA_W-1:0] drv_wdata [N_REQ];
    bit                inflight  [N_REQ];
    int                acc_cyc   [N_REQ];
    bit                rand_mode = 0;
    bit                keep0     = 0;

    // SIF model
    logic [DATA_W-1:0] sif_mem [logic [ADDR_W-1:0]];
    int                rd_due  = -1;
    logic [DATA_W-1:0] rd_val  = '0;
    int                rd_strobes = 0;

    // transaction-level reference model
    logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
    int                m_ptr = 0;
    int                m_free = 0;
    bit                cur_valid = 0;
    int                cur_id = 0;
    bit                cur_we = 0;
    logic [ADDR_W-1:0] cur_addr = '0;
    logic [DATA_W-1:0] cur_wdata = '0;
    int                cur_t = 0;
    logic [ADDR_W-1:0] m_xa_addr = '0;
    logic [DATA_W-1:0] m_xa_wd = '0;
    logic [DATA_W-1:0] last_rdata = '0;
    int                waits [N_REQ];
    int                max_wait = 0;
    int                acc_id_q [$];
    int                acc_t_q [$];
    int                rsp_id_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] default_data(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) ^ DATA_W'(16'hC3A5);
    endfunction

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : default_data(a);
    endfunction

    task automatic apply();
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_valid[i]                    = drv_valid[i];
            bus.req_we[i]                       = drv_we[i];
            bus.req_addr[i*ADDR_W +: ADDR_W]    = drv_addr[i];
            bus.req_wdata[i*DATA_W +: DATA_W]   = drv_wdata[i];
        end
    endtask

    task automatic post(input int i, input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        drv_valid[i] = 1'b1;
        drv_we[i]    = we;
        drv_addr[i]  = a;
        drv_wdata[i] = d;
        apply();
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (inflight[i]) drv_valid[i] = 1'b0;
        end
        if (keep0 && !drv_valid[0] && !inflight[0]) begin
            post(0, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
        end
        if (rand_mode) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!drv_valid[i] && !inflight[i] && $urandom_range(0, 2) == 0) begin
                    post(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
                end
            end
        end
        bus.xa_data_rd = (cyc == rd_due) ? rd_val : DATA_W'($urandom);
        apply();
    endtask

    task automatic wait_acc(input int id, output int t);
        t = -1;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (inflight[id]) begin
                t = acc_cyc[id];
                return;
            end
        end
        check_eq("accept_timeout", 32'(id), 32'hFFFF_FFFF);
    endtask

    task automatic wait_rsp(input int id);
        for (int n = 0; n < 100; n++) begin
            if (!inflight[id]) return;
            tick();
        end
        check_eq("response_timeout", 32'(id), 32'hFFFF_FFFF);
    endtask

    // reference model and SIF model, evaluated mid-cycle
    task automatic monitor_cycle();
        logic [N_REQ-1:0] exp_ready;
        logic [N_REQ-1:0] exp_rsp;
        logic [N_REQ-1:0] acc;
        bit               exp_wr;
        bit               exp_rd;
        bit               exp_busy;
        int               rsp_t;
        int               w;
        if (rst) begin
            check_eq("ready_in_reset", 32'(bus.req_ready), 32'd0);
            m_ptr      = 0;
            m_free     = cyc + 1;
            cur_valid  = 0;
            m_xa_addr  = '0;
            m_xa_wd    = '0;
            last_rdata = '0;
            for (int i = 0; i < N_REQ; i++) begin
                inflight[i] = 0;
                waits[i]    = 0;
            end
            return;
        end
        exp_wr   = 0;
        exp_rd   = 0;
        exp_busy = 0;
        exp_rsp  = '0;
        if (cur_valid) begin
            rsp_t = cur_t + 2 + (cur_we ? 0 : RD_LAT);
            if (cyc == cur_t + 1) begin
                exp_wr    = cur_we;
                exp_rd    = !cur_we;
                m_xa_addr = cur_addr;
                m_xa_wd   = cur_wdata;
            end
            exp_busy = (cyc > cur_t) && (cyc <= rsp_t);
            if (cyc == rsp_t) begin
                exp_rsp[cur_id] = 1'b1;
                if (!cur_we) last_rdata = ref_rd(cur_addr);
                cur_valid = 0;
            end
        end
        check_eq("xa_wr_s", 32'(bus.xa_wr_s), 32'(exp_wr));
        check_eq("xa_rd_s", 32'(bus.xa_rd_s), 32'(exp_rd));
        check_eq("xa_addr", 32'(bus.xa_addr), 32'(m_xa_addr));
        check_eq("xa_data_wr", 32'(bus.xa_data_wr), 32'(m_xa_wd));
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
        check_eq("rsp_rdata", 32'(bus.rsp_rdata), 32'(last_rdata));
        check_eq("busy", 32'(bus.busy), 32'(exp_busy));

        if (bus.xa_wr_s) sif_mem[bus.xa_addr] = bus.xa_data_wr;
        if (bus.xa_rd_s) begin
            rd_strobes++;
            rd_due = cyc + RD_LAT;
            rd_val = sif_mem.exists(bus.xa_addr) ? sif_mem[bus.xa_addr] : default_data(bus.xa_addr);
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.rsp_valid[i]) begin
                inflight[i] = 0;
                rsp_id_q.push_back(i);
            end
        end

        w = -1;
        if (!cur_valid && cyc >= m_free) begin
            for (int k = 0; k < N_REQ; k++) begin
                int c = (m_ptr + k) % N_REQ;
                if (w < 0 && bus.req_valid[c]) w = c;
            end
        end
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        check_eq("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        if (w >= 0) begin
            cur_valid = 1;
            cur_id    = w;
            cur_we    = bus.req_we[w];
            cur_addr  = bus.req_addr[w*ADDR_W +: ADDR_W];
            cur_wdata = bus.req_wdata[w*DATA_W +: DATA_W];
            cur_t     = cyc;
            if (cur_we) ref_mem[cur_addr] = cur_wdata;
            m_ptr  = (w + 1) % N_REQ;
            m_free = cyc + 3 + (cur_we ? 0 : RD_LAT);
        end

        acc = bus.req_valid & bus.req_ready;
        for (int i = 0; i < N_REQ; i++) begin
            if (acc[i]) begin
                inflight[i] = 1;
                acc_cyc[i]  = cyc;
                acc_id_q.push_back(i);
                acc_t_q.push_back(cyc);
                for (int j = 0; j < N_REQ; j++) begin
                    if (j != i && bus.req_valid[j]) begin
                        waits[j]++;
                        if (waits[j] > max_wait) max_wait = waits[j];
                    end
                end
                waits[i] = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_cycle();
        end
    end

    initial begin
        int t;
        int t2;
        int zeros;
        int idx3;
        for (int i = 0; i < N_REQ; i++) begin
            drv_valid[i] = 1'b0;
            drv_we[i]    = 1'b0;
            drv_addr[i]  = '0;
            drv_wdata[i] = '0;
            inflight[i]  = 0;
            acc_cyc[i]   = 0;
            waits[i]     = 0;
        end
        apply();
        bus.xa_data_rd = '0;

        // held in reset with all four requesters posting writes
        tick();
        tick();
        for (int i = 0; i < N_REQ; i++) post(i, 1'b1, ADDR_W'(i), DATA_W'(16'h1000 + i));
        tick();
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check_eq("rst_xa_addr", 32'(bus.xa_addr), 32'd0);
        check_eq("rst_xa_data_wr", 32'(bus.xa_data_wr), 32'd0);
        check_eq("rst_strobes", 32'({bus.xa_wr_s, bus.xa_rd_s}), 32'd0);
        acc_id_q.delete();
        acc_t_q.delete();
        rsp_id_q.delete();
        rst = 1'b0;
        for (int n = 0; n < 60 && rsp_id_q.size() < 4; n++) tick();
        check_eq("rr_rsp_count", 32'(rsp_id_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < acc_id_q.size() && k < rsp_id_q.size(); k++) begin
            check_eq("rr_grant_order", 32'(acc_id_q[k]), 32'(k));
            check_eq("rr_rsp_order", 32'(rsp_id_q[k]), 32'(k));
            if (k > 0) check_eq("rr_grant_spacing", 32'(acc_t_q[k] - acc_t_q[k-1]), 32'd3);
        end
        tick();
        check_eq("ptr_wrapped", 32'(dut.ptr), 32'd0);

        // single write from requester 0
        rd_strobes = 0;
        post(0, 1'b1, 16'h0010, 16'hBEEF);
        wait_acc(0, t);
        check_eq("wr_strobe", 32'(bus.xa_wr_s), 32'd1);
        check_eq("wr_addr", 32'(bus.xa_addr), 32'h0010);
        check_eq("wr_data", 32'(bus.xa_data_wr), 32'hBEEF);
        tick();
        check_eq("wr_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
        tick();
        check_eq("wr_no_rd_strobe", 32'(rd_strobes), 32'd0);

        // single read from requester 2
        ref_mem[16'h0020] = 16'h1234;
        sif_mem[16'h0020] = 16'h1234;
        post(2, 1'b0, 16'h0020, 16'h0000);
        wait_acc(2, t);
        check_eq("rd_strobe", 32'(bus.xa_rd_s), 32'd1);
        tick();
        tick();
        tick();
        check_eq("rd_latency", 32'(cyc - t), 32'd4);
        check_eq("rd_rsp_valid", 32'(bus.rsp_valid), 32'b0100);
        check_eq("rd_rsp_rdata", 32'(bus.rsp_rdata), 32'h1234);
        wait_rsp(2);

        // fairness: requester 0 always requesting, requester 3 once
        max_wait = 0;
        acc_id_q.delete();
        keep0 = 1;
        for (int n = 0; n < 60; n++) begin
            zeros = 0;
            foreach (acc_id_q[k]) if (acc_id_q[k] == 0) zeros++;
            if (zeros >= 2) break;
            tick();
        end
        acc_id_q.delete();
        post(3, 1'b1, 16'h0003, 16'h3333);
        idx3 = -1;
        for (int n = 0; n < 60 && idx3 < 0; n++) begin
            tick();
            foreach (acc_id_q[k]) if (acc_id_q[k] == 3 && idx3 < 0) idx3 = k;
        end
        zeros = 0;
        for (int k = 0; k < idx3; k++) if (acc_id_q[k] == 0) zeros++;
        check_eq("fair_req3_granted", 32'(idx3 >= 0), 32'd1);
        check_eq("fair_req3_before_2nd_req0", 32'(zeros < 2), 32'd1);
        keep0 = 0;
        for (int n = 0; n < 60 && (inflight[0] || inflight[3] || drv_valid[0]); n++) tick();
        check_eq("fair_max_wait", 32'(max_wait <= N_REQ - 1), 32'd1);

        // reset during WAIT of a requester 1 read
        post(1, 1'b0, 16'h0030, 16'h0000);
        wait_acc(1, t);
        tick();
        rst = 1'b1;
        tick();
        check_eq("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_xa_addr", 32'(bus.xa_addr), 32'd0);
        check_eq("abort_strobes", 32'({bus.xa_wr_s, bus.xa_rd_s}), 32'd0);
        check_eq("abort_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        rst = 1'b0;
        tick();
        post(1, 1'b0, 16'h0030, 16'h0000);
        wait_acc(1, t);
        wait_rsp(1);
        check_eq("reread_rdata", 32'(bus.rsp_rdata), 32'(default_data(16'h0030)));

        // back-to-back write then read from requester 1
        post(1, 1'b1, 16'h0005, 16'hAAAA);
        wait_acc(1, t);
        wait_rsp(1);
        post(1, 1'b0, 16'h0005, 16'h0000);
        wait_acc(1, t2);
        check_eq("b2b_accept_gap", 32'(t2 - t), 32'd3);
        wait_rsp(1);
        check_eq("b2b_rdata", 32'(bus.rsp_rdata), 32'hAAAA);

        // randomized traffic from all requesters
        max_wait = 0;
        acc_id_q.delete();
        rand_mode = 1;
        repeat (3000) tick();
        rand_mode = 0;
        for (int n = 0; n < 200; n++) begin
            bit idle_all = 1;
            for (int i = 0; i < N_REQ; i++) if (inflight[i] || drv_valid[i]) idle_all = 0;
            if (idle_all) break;
            tick();
        end
        check_eq("rand_activity", 32'(acc_id_q.size() > 200), 32'd1);
        check_eq("rand_max_wait", 32'(max_wait <= N_REQ - 1), 32'd1);
        tick();
        check_eq("rand_drained", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
